// File: rtl/psum_reducer.sv
// psum_reducer: sums the nine 16-bit lanes of each beat, then accumulates NUM_CH beats into one result.
// Define PSUM_REDUCER_SAT_EN for saturating accumulation; the default build wraps modulo 2^ACC_W.
module psum_reducer #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [143:0]     psum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

  logic             w_stall;
  logic             w_accept;
  logic [19:0]      w_lane_sum;
  logic [CNT_W-1:0] r_ch_cnt;
  logic             r_s1_valid;
  logic             r_s1_last;
  logic [19:0]      r_s1_sum;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_out_data;
  logic             r_out_valid;
  logic [ACC_W-1:0] w_add_res;

  assign w_stall   = r_out_valid & ~out_ready;
  assign in_ready  = ~w_stall & ~clr;
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Nine lanes of at most 0xFFFF sum to under 2^20, so 20 bits never overflow here.
  always_comb begin
    w_lane_sum = '0;
    for (int i = 0; i < 9; i++) begin
      w_lane_sum = w_lane_sum + 20'(psum[16*i +: 16]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch_cnt   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sum   <= '0;
    end else if (clr) begin
      r_ch_cnt   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      r_s1_last  <= w_accept && (r_ch_cnt == LAST_CH);
      r_s1_sum   <= w_lane_sum;
      if (w_accept) begin
        r_ch_cnt <= (r_ch_cnt == LAST_CH) ? '0 : r_ch_cnt + 1'b1;
      end
    end
  end

`ifdef PSUM_REDUCER_SAT_EN
  logic [ACC_W:0] w_add_full;
  logic           w_add_ovf;
  logic           r_acc_sat;
  logic           r_out_ovf;

  // Once the group has clamped, every later addition in it reports clamped too.
  assign w_add_full = {1'b0, r_acc} + {1'b0, ACC_W'(r_s1_sum)};
  assign w_add_ovf  = w_add_full[ACC_W] | r_acc_sat;
  assign w_add_res  = w_add_ovf ? '1 : w_add_full[ACC_W-1:0];
  assign out_ovf    = r_out_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_sat <= 1'b0;
      r_out_ovf <= 1'b0;
    end else if (clr) begin
      r_acc_sat <= 1'b0;
      r_out_ovf <= 1'b0;
    end else if (!w_stall && r_s1_valid) begin
      if (r_s1_last) begin
        r_out_ovf <= w_add_ovf;
        r_acc_sat <= 1'b0;
      end else begin
        r_acc_sat <= w_add_ovf;
      end
    end
  end
`else
  assign w_add_res = r_acc + ACC_W'(r_s1_sum);
  assign out_ovf   = 1'b0;
`endif

  // A finished result either replaces the held one or, with nothing new, lets it drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (clr) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_s1_valid & r_s1_last;
      if (r_s1_valid) begin
        if (r_s1_last) begin
          r_out_data <= w_add_res;
          r_acc      <= '0;
        end else begin
          r_acc <= w_add_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_reducer.sv
// tb_psum_reducer: directed checks of psum_reducer using three instances (NUM_CH=4, NUM_CH=2/ACC_W=20, NUM_CH=1).
// Expected overflow behaviour follows whether PSUM_REDUCER_SAT_EN is defined for the build.
module tb_psum_reducer;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         inValid;
  logic         outReady;
  logic [143:0] psum;

  logic         inReady4, outValid4, outOvf4;
  logic [23:0]  outData4;
  logic         inReady2, outValid2, outOvf2;
  logic [19:0]  outData2;
  logic         inReady1, outValid1, outOvf1;
  logic [23:0]  outData1;

  int nChecks;
  int nFail;

  psum_reducer #(.NUM_CH(4), .ACC_W(24)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(inValid), .in_ready(inReady4),
    .psum(psum), .out_valid(outValid4), .out_ready(outReady),
    .out_data(outData4), .out_ovf(outOvf4)
  );

  psum_reducer #(.NUM_CH(2), .ACC_W(20)) dut2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(inValid), .in_ready(inReady2),
    .psum(psum), .out_valid(outValid2), .out_ready(outReady),
    .out_data(outData2), .out_ovf(outOvf2)
  );

  psum_reducer #(.NUM_CH(1), .ACC_W(24)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(inValid), .in_ready(inReady1),
    .psum(psum), .out_valid(outValid1), .out_ready(outReady),
    .out_data(outData1), .out_ovf(outOvf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic v, input logic [15:0] lane);
    @(negedge clk);
    inValid = v;
    psum    = {9{lane}};
  endtask

  task automatic do_reset;
    @(negedge clk);
    inValid  = 1'b0;
    clr      = 1'b0;
    outReady = 1'b1;
    psum     = '0;
    rst      = 1'b1;
    #2;
    rst      = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    nChecks++; if (outValid4 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid: got %0d expected 0", outValid4); end
    nChecks++; if (outData4 !== 24'd0) begin nFail++; $display("[TB] FAIL reset_data: got %0d expected 0", outData4); end
    nChecks++; if (outOvf4 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_ovf: got %0d expected 0", outOvf4); end
    nChecks++; if (inReady4 !== 1'b1) begin nFail++; $display("[TB] FAIL reset_in_ready: got %0d expected 1", inReady4); end
    nChecks++; if (outValid1 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid1: got %0d expected 0", outValid1); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd1);
    drive(1'b0, 16'd0);
    nChecks++; if (outValid4 !== 1'b0) begin nFail++; $display("[TB] FAIL basic_latency: got %0d expected 0", outValid4); end
    drive(1'b0, 16'd0);
    nChecks++; if (outValid4 !== 1'b1) begin nFail++; $display("[TB] FAIL basic_valid: got %0d expected 1", outValid4); end
    nChecks++; if (outData4 !== 24'd36) begin nFail++; $display("[TB] FAIL basic_data: got %0d expected 36", outData4); end
    nChecks++; if (outOvf4 !== 1'b0) begin nFail++; $display("[TB] FAIL basic_ovf: got %0d expected 0", outOvf4); end
    drive(1'b0, 16'd0);
    nChecks++; if (outValid4 !== 1'b0) begin nFail++; $display("[TB] FAIL basic_drain: got %0d expected 0", outValid4); end
  endtask

  task automatic test_stall;
    do_reset();
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd1);
    drive(1'b0, 16'd0);
    drive(1'b0, 16'd0);
    nChecks++; if (outData4 !== 24'd36) begin nFail++; $display("[TB] FAIL stall_first: got %0d expected 36", outData4); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'd2);
      #1;
      nChecks++; if (inReady4 !== 1'b0) begin nFail++; $display("[TB] FAIL stall_in_ready: got %0d expected 0", inReady4); end
      nChecks++; if (outValid4 !== 1'b1) begin nFail++; $display("[TB] FAIL stall_valid: got %0d expected 1", outValid4); end
      nChecks++; if (outData4 !== 24'd36) begin nFail++; $display("[TB] FAIL stall_hold: got %0d expected 36", outData4); end
    end
    drive(1'b1, 16'd2);
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 16'd2);
    drive(1'b0, 16'd0);
    nChecks++; if (outValid4 !== 1'b0) begin nFail++; $display("[TB] FAIL stall_release: got %0d expected 0", outValid4); end
    drive(1'b0, 16'd0);
    nChecks++; if (outValid4 !== 1'b1) begin nFail++; $display("[TB] FAIL stall_next_valid: got %0d expected 1", outValid4); end
    nChecks++; if (outData4 !== 24'd72) begin nFail++; $display("[TB] FAIL stall_next_data: got %0d expected 72", outData4); end
  endtask

  task automatic test_overflow;
    logic [19:0] expData;
    logic        expOvf;
`ifdef PSUM_REDUCER_SAT_EN
    expData = 20'hFFFFF;
    expOvf  = 1'b1;
`else
    expData = 20'd131054;
    expOvf  = 1'b0;
`endif
    do_reset();
    drive(1'b1, 16'hFFFF);
    drive(1'b1, 16'hFFFF);
    drive(1'b0, 16'd0);
    drive(1'b0, 16'd0);
    nChecks++; if (outValid2 !== 1'b1) begin nFail++; $display("[TB] FAIL ovf_valid: got %0d expected 1", outValid2); end
    nChecks++; if (outData2 !== expData) begin nFail++; $display("[TB] FAIL ovf_data: got %0d expected %0d", outData2, expData); end
    nChecks++; if (outOvf2 !== expOvf) begin nFail++; $display("[TB] FAIL ovf_flag: got %0d expected %0d", outOvf2, expOvf); end
  endtask

  task automatic test_clear;
    int          results;
    logic [23:0] seen;
    results = 0;
    seen    = '0;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (outValid4 === 1'b1) begin
        results++;
        seen = outData4;
      end
      if (c < 2) begin
        inValid = 1'b1; psum = {9{16'd5}};
      end else if (c == 2) begin
        clr = 1'b1; inValid = 1'b1; psum = {9{16'd5}};
        #1;
        nChecks++; if (inReady4 !== 1'b0) begin nFail++; $display("[TB] FAIL clr_in_ready: got %0d expected 0", inReady4); end
      end else if (c < 7) begin
        clr = 1'b0; inValid = 1'b1; psum = {9{16'd1}};
      end else begin
        inValid = 1'b0; psum = '0;
      end
    end
    nChecks++; if (results !== 1) begin nFail++; $display("[TB] FAIL clr_count: got %0d expected 1", results); end
    nChecks++; if (seen !== 24'd36) begin nFail++; $display("[TB] FAIL clr_data: got %0d expected 36", seen); end
  endtask

  task automatic test_async_reset;
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd1);
    drive(1'b1, 16'd7);
    drive(1'b1, 16'd7);
    drive(1'b0, 16'd0);
    nChecks++; if (outData4 !== 24'd36) begin nFail++; $display("[TB] FAIL arst_before: got %0d expected 36", outData4); end
    #2;
    rst = 1'b1;
    #1;
    nChecks++; if (outValid4 !== 1'b0) begin nFail++; $display("[TB] FAIL arst_valid: got %0d expected 0", outValid4); end
    nChecks++; if (outData4 !== 24'd0) begin nFail++; $display("[TB] FAIL arst_data: got %0d expected 0", outData4); end
    nChecks++; if (outOvf4 !== 1'b0) begin nFail++; $display("[TB] FAIL arst_ovf: got %0d expected 0", outOvf4); end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd3);
    drive(1'b0, 16'd0);
    drive(1'b0, 16'd0);
    nChecks++; if (outValid4 !== 1'b1) begin nFail++; $display("[TB] FAIL arst_next_valid: got %0d expected 1", outValid4); end
    nChecks++; if (outData4 !== 24'd108) begin nFail++; $display("[TB] FAIL arst_next_data: got %0d expected 108", outData4); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        nChecks++; if (outValid1 !== 1'b1) begin nFail++; $display("[TB] FAIL b2b_valid[%0d]: got %0d expected 1", c - 2, outValid1); end
        nChecks++; if (outData1 !== 24'(9 * (c - 2))) begin nFail++; $display("[TB] FAIL b2b_data[%0d]: got %0d expected %0d", c - 2, outData1, 9 * (c - 2)); end
      end
      if (c < 10) begin
        inValid = 1'b1;
        psum    = {9{16'(c)}};
      end else begin
        inValid = 1'b0;
        psum    = '0;
      end
    end
    @(negedge clk);
    nChecks++; if (outValid1 !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_drain: got %0d expected 0", outValid1); end
  endtask

  initial begin
    nChecks  = 0;
    nFail    = 0;
    rst      = 1'b1;
    clr      = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    psum     = '0;
    test_reset();
    test_basic();
    test_stall();
    test_overflow();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/psum_reducer.md
PSUM_REDUCER -- requirements
Module: psum_reducer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_CH, 4, input-channel beats summed per result; legal range 1..256.
- ACC_W, 24, accumulator and result width; legal minimum 20.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- clr, input, 1, synchronous flush of the current group.
- in_valid, input, 1, psum beat present.
- in_ready, output, 1, block accepts a beat this cycle.
- psum, input, 144, nine unsigned 16-bit lanes; lane i = psum[16i+15:16i].
- out_valid, output, 1, result present.
- out_ready, input, 1, downstream accepts the result.
- out_data, output, ACC_W, reduced, channel-accumulated result.
- out_ovf, output, 1, overflow indicator for the current result.

Function
REQ-003 A beat SHALL be accepted on any rising edge where in_valid and in_ready are both 1.
REQ-004 stall = out_valid AND NOT out_ready; in_ready SHALL equal NOT stall AND NOT clr.
REQ-005 Stage 1 SHALL register the unsigned 20-bit sum of all nine lanes of the accepted beat, together with s1_valid and s1_last.
REQ-006 Channel counter ch_cnt (0..NUM_CH-1) SHALL increment per accepted beat and wrap to 0 after NUM_CH-1. s1_last SHALL equal 1 when the beat was accepted with ch_cnt = NUM_CH-1.
REQ-007 Stage 2 SHALL update only when stall = 0.
- s1_valid and not s1_last: acc <= acc + s1_sum.
- s1_valid and s1_last: out_data <= acc + s1_sum; out_valid <= 1; acc <= 0.
REQ-008 Result latency: if the last beat of a group is accepted at edge k, out_valid SHALL rise at edge k+1.
REQ-009 While stall = 1, stage 1, acc, ch_cnt, out_data and out_ovf SHALL hold.
REQ-010 On out_valid AND out_ready with no new result at that edge, out_valid SHALL clear. If a new result completes at the same edge, it SHALL replace the old one and out_valid SHALL stay 1.
REQ-011 Throughput: with out_ready held at 1, one beat SHALL be accepted every cycle. NUM_CH = 1 SHALL therefore yield one result per cycle.
REQ-012 clr = 1 SHALL clear ch_cnt, acc, s1_valid, out_valid and out_ovf at that edge. A concurrent in_valid beat SHALL be dropped (in_ready = 0).
REQ-013 Accumulation SHALL be unsigned. Overflow handling SHALL follow REQ-016/REQ-017.

Reset
REQ-014 rst = 1 SHALL immediately, without a clock, force ch_cnt = 0, acc = 0, s1_valid = 0, s1_last = 0, out_valid = 0, out_data = 0, out_ovf = 0.
REQ-015 A reset asserted mid-group SHALL discard that group. The first beat accepted after reset release SHALL be channel 0.

Configuration
REQ-016 With PSUM_REDUCER_SAT_EN defined:
- any acc or result addition exceeding 2^ACC_W-1 SHALL clamp to 2^ACC_W-1;
- once clamped, acc SHALL stay clamped for the rest of the group;
- out_ovf SHALL be 1 with that result.
REQ-017 Without PSUM_REDUCER_SAT_EN:
- additions SHALL wrap modulo 2^ACC_W;
- out_ovf SHALL be constant 0.

Verification
REQ-018 NUM_CH=4, out_ready=1, four beats with every lane = 1 -> out_data = 36 at the edge after the 4th acceptance; out_ovf = 0.
REQ-019 out_ready=0 while one result is pending, in_valid=1 -> in_ready = 0 and out_data stable. After out_ready=1 for one cycle, the next group of four 2-lane beats (lanes = 2) -> out_data = 72.
REQ-020 ACC_W=20, NUM_CH=2, two beats with all lanes = 0xFFFF:
- with PSUM_REDUCER_SAT_EN -> out_data = 0xFFFFF, out_ovf = 1;
- without it -> out_data = 131054, out_ovf = 0.
REQ-021 NUM_CH=4: two beats of lanes = 5, then clr, then four beats of lanes = 1 -> single result 36. No result appears from the flushed beats.
REQ-022 rst pulsed asynchronously between clock edges after two beats -> all outputs 0 immediately. Then four beats of lanes = 3 -> out_data = 108.
REQ-023 NUM_CH=1, ten back-to-back beats with lane value = beat index n -> ten consecutive results 9n, one per cycle, with out_valid continuously 1.
